// File: rtl/cfg_loader_pkg.sv
// Shared types, sizing constants and CRC-8 helper for the connection-block frame loader.
package cfg_loader_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StSetup,
        StStrobe,
        StHold,
        StCheck,
        StDone
    } state_e;

    localparam int unsigned TotalBits = 9 * 6 + 2 * 2;
    localparam int unsigned NumWords  = (TotalBits + 8 - 1) / 8;
    localparam int unsigned NumMems   = 9 + 2;

    localparam logic [7:0] CrcPoly = 8'h07;

    function automatic logic [7:0] crc8_update(input logic [7:0] crc, input logic bit_in);
        logic fb;
        fb = crc[7] ^ bit_in;
        return {crc[6:0], 1'b0} ^ (fb ? CrcPoly : 8'h00);
    endfunction

endpackage

// File: rtl/cfg_addr_gen.sv
// Memory-select / bit-index counter pair; presents the decoder address of the current bit.
module cfg_addr_gen #(
    parameter int NUM_WIDE    = 9,
    parameter int WIDE_BITS   = 6,
    parameter int NUM_NARROW  = 2,
    parameter int NARROW_BITS = 2,
    parameter int SEL_W       = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clear,
    input  logic       advance,
    output logic [0:6] address,
    output logic       last
);

    logic [SEL_W-1:0] mem_idx;
    logic [2:0]       bit_idx;
    logic             is_wide;
    logic             mem_last_bit;

    always_comb begin
        is_wide      = mem_idx < SEL_W'(NUM_WIDE);
        mem_last_bit = is_wide ? (bit_idx == 3'(WIDE_BITS - 1))
                               : (bit_idx == 3'(NARROW_BITS - 1));
        last         = mem_last_bit && (mem_idx == SEL_W'(NUM_WIDE + NUM_NARROW - 1));
        // Narrow memories only decode address[0]; address[1:2] must stay low.
        address      = {(is_wide ? bit_idx : {bit_idx[0], 2'b00}), mem_idx};
    end

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            mem_idx <= '0;
            bit_idx <= '0;
        end else if (advance) begin
            if (mem_last_bit) begin
                bit_idx <= '0;
                mem_idx <= mem_idx + 1'b1;
            end else begin
                bit_idx <= bit_idx + 1'b1;
            end
        end
    end

endmodule

// File: rtl/cb_cfg_frame_loader.sv
// Unpacks a byte-stream CB bitstream LSB-first and writes it with setup/strobe/hold cycles.
// Optional CRC-8 trailer check enabled by defining CFG_LOADER_CRC_EN.
module cb_cfg_frame_loader
    import cfg_loader_pkg::*;
#(
    parameter int DATA_W      = 8,
    parameter int NUM_WIDE    = 9,
    parameter int WIDE_BITS   = 6,
    parameter int NUM_NARROW  = 2,
    parameter int NARROW_BITS = 2,
    parameter int SEL_W       = 4
) (
    input  logic              prog_clk,
    input  logic              pReset,
    input  logic              start,
    input  logic [DATA_W-1:0] cfg_word,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    output logic              enable,
    output logic [0:6]        address,
    output logic              data_in,
    output logic              busy,
    output logic              done,
    output logic              crc_err
);

    localparam int BitsW = $clog2(DATA_W + 1);

    state_e            state;
    logic [DATA_W-1:0] shreg;
    logic [BitsW-1:0]  bits_left;
    logic              last_bit;
    logic [0:6]        gen_address;
    logic              gen_last;

    cfg_addr_gen #(
        .NUM_WIDE    (NUM_WIDE),
        .WIDE_BITS   (WIDE_BITS),
        .NUM_NARROW  (NUM_NARROW),
        .NARROW_BITS (NARROW_BITS),
        .SEL_W       (SEL_W)
    ) u_addr_gen (
        .clk     (prog_clk),
        .rst     (pReset),
        .clear   (state == StIdle && start),
        .advance (state == StStrobe),
        .address (gen_address),
        .last    (gen_last)
    );

`ifdef CFG_LOADER_CRC_EN
    logic [7:0] crc;
    logic       crc_err_q;
    assign crc_err = crc_err_q;
`else
    assign crc_err = 1'b0;
`endif

    always_ff @(posedge prog_clk) begin
        if (pReset) begin
            state     <= StIdle;
            shreg     <= '0;
            bits_left <= '0;
            last_bit  <= 1'b0;
            cfg_ready <= 1'b0;
            enable    <= 1'b0;
            address   <= '0;
            data_in   <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
`ifdef CFG_LOADER_CRC_EN
            crc       <= '0;
            crc_err_q <= 1'b0;
`endif
        end else begin
            enable <= 1'b0;
            done   <= 1'b0;
            unique case (state)
                StIdle: begin
                    if (start) begin
                        state     <= StFetch;
                        busy      <= 1'b1;
                        cfg_ready <= 1'b1;
`ifdef CFG_LOADER_CRC_EN
                        crc       <= '0;
                        crc_err_q <= 1'b0;
`endif
                    end
                end
                StFetch: begin
                    if (cfg_valid) begin
                        shreg     <= cfg_word;
                        bits_left <= BitsW'(DATA_W);
                        cfg_ready <= 1'b0;
                        address   <= gen_address;
                        data_in   <= cfg_word[0];
                        last_bit  <= gen_last;
                        state     <= StSetup;
                    end
                end
                StSetup: begin
                    enable <= 1'b1;
                    state  <= StStrobe;
                end
                StStrobe: begin
`ifdef CFG_LOADER_CRC_EN
                    crc <= crc8_update(crc, data_in);
`endif
                    state <= StHold;
                end
                StHold: begin
                    // Last config bit wins over word exhaustion so pad bits are never written.
                    if (last_bit) begin
`ifdef CFG_LOADER_CRC_EN
                        cfg_ready <= 1'b1;
                        state     <= StCheck;
`else
                        done      <= 1'b1;
                        busy      <= 1'b0;
                        state     <= StDone;
`endif
                    end else if (bits_left == BitsW'(1)) begin
                        cfg_ready <= 1'b1;
                        state     <= StFetch;
                    end else begin
                        shreg     <= shreg >> 1;
                        bits_left <= bits_left - 1'b1;
                        address   <= gen_address;
                        data_in   <= shreg[1];
                        last_bit  <= gen_last;
                        state     <= StSetup;
                    end
                end
`ifdef CFG_LOADER_CRC_EN
                StCheck: begin
                    if (cfg_valid) begin
                        crc_err_q <= (cfg_word[7:0] != crc);
                        cfg_ready <= 1'b0;
                        done      <= 1'b1;
                        busy      <= 1'b0;
                        state     <= StDone;
                    end
                end
`endif
                StDone: begin
                    state <= StIdle;
                end
                default: begin
                    state <= StIdle;
                end
            endcase
        end
    end

endmodule
